// File: rtl/decode_exec_pkg.sv
// Shared decode definitions for decode_exec_unit: opcode/funct encodings,
// ALU operation enum and the decoded control word.
package decode_exec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_LINK
  } alu_op_t;

  typedef struct packed {
    logic    reg_dst;   // 1: rd, 0: rt
    logic    alu_src;   // 1: immediate operand B
    logic    ext_op;    // 1: sign-extend imm16
    logic    link;      // jal: dest $31, operand A = pc
    logic    reg_write;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/decode_exec_alu.sv
// Combinational ALU for decode_exec_unit; LINK returns a + 8.
module exec_alu
  import decode_exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t           alu_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, a < b};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $unsigned($signed(b) >>> shamt);
      ALU_LUI:  result = b << shamt;
      ALU_LINK: result = a + DATA_W'(8);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/decode_exec_unit.sv
// Single-cycle decode / 32x32 register file / ALU slice for the MIPS-subset core.
// Define DECODE_EXEC_TRACE_EN to print each register write-back in simulation.
module decode_exec_unit
  import decode_exec_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] REG_INIT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] alu_result,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];
  assign funct = instr[5:0];
  assign imm16 = instr[15:0];

  ctrl_t ctrl;
  logic  legal;

  always_comb begin
    ctrl  = '0;
    legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          F_ADD, F_ADDU:  ctrl.alu_op = ALU_ADD;
          F_SUB, F_SUBU:  ctrl.alu_op = ALU_SUB;
          F_AND:          ctrl.alu_op = ALU_AND;
          F_OR:           ctrl.alu_op = ALU_OR;
          F_XOR:          ctrl.alu_op = ALU_XOR;
          F_NOR:          ctrl.alu_op = ALU_NOR;
          F_SLT:          ctrl.alu_op = ALU_SLT;
          F_SLTU:         ctrl.alu_op = ALU_SLTU;
          F_SLL, F_SLLV:  ctrl.alu_op = ALU_SLL;
          F_SRL, F_SRLV:  ctrl.alu_op = ALU_SRL;
          F_SRA, F_SRAV:  ctrl.alu_op = ALU_SRA;
          default:        legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.ext_op    = 1'b1;
        ctrl.reg_write = 1'b1;
        case (op)
          OP_SLTI:  ctrl.alu_op = ALU_SLT;
          OP_SLTIU: ctrl.alu_op = ALU_SLTU;
          default:  ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (op)
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_XORI: ctrl.alu_op = ALU_XOR;
          default: ctrl.alu_op = ALU_LUI;
        endcase
      end
      OP_JAL: begin
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_LINK;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) ctrl.reg_write = 1'b0;
  end

  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] rs_val, rt_val, imm_ext, a_op, b_op, alu_raw;
  logic [4:0]        sh_amt;

  // $0 is never written, so any read of address 0 is forced to zero here
  assign rs_val   = (rs == 5'd0)       ? '0 : regs[rs];
  assign rt_val   = (rt == 5'd0)       ? '0 : regs[rt];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

  assign imm_ext = ctrl.ext_op ? {{(DATA_W-16){imm16[15]}}, imm16}
                               : {{(DATA_W-16){1'b0}}, imm16};
  assign a_op    = ctrl.link ? pc : rs_val;
  assign b_op    = ctrl.alu_src ? imm_ext : rt_val;
  // funct[2] separates variable shifts (sllv/srlv/srav) from shamt shifts
  assign sh_amt  = ctrl.alu_src ? 5'd16 : (funct[2] ? rs_val[4:0] : shamt);

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op (ctrl.alu_op),
    .a      (a_op),
    .b      (b_op),
    .shamt  (sh_amt),
    .result (alu_raw)
  );

  assign alu_result = legal ? alu_raw : '0;
  assign wb_data    = alu_result;
  assign wb_addr    = ctrl.link ? 5'd31 : (ctrl.reg_dst ? rd : rt);
  assign wb_we      = reset && instr_valid && ctrl.reg_write && (wb_addr != 5'd0);
  assign illegal    = reset && instr_valid && !legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= REG_INIT;
    end else if (wb_we) begin
      regs[wb_addr] <= wb_data;
    end
  end

`ifdef DECODE_EXEC_TRACE_EN
  always @(posedge clk) begin
    if (wb_we) $display("@%08h: $%02d <= %08h", pc, wb_addr, wb_data);
  end
`else
`endif

endmodule

// File: tb/tb_decode_exec_unit.sv
// Self-checking bench for decode_exec_unit: directed plan plus random instructions
// checked against an instruction-level reference model.
module tb_decode_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr, pc;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data, alu_result, wb_data;
  logic        wb_we, illegal;
  logic [4:0]  wb_addr;

  decode_exec_unit dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_result(alu_result),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mregs [32];
  logic [31:0] cur_pc = 32'h0000_1000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rt_enc(input logic [5:0] f, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d,
                                         input logic [4:0] sh);
    return {6'h00, s, t, d, sh, f};
  endfunction

  function automatic logic [31:0] it_enc(input logic [5:0] o, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic logic [31:0] rv(input logic [4:0] a);
    return (a == 0) ? 32'h0 : mregs[a];
  endfunction

  // Reference: architectural meaning of each instruction, straight from the ISA rules
  task automatic model(input logic [31:0] ins, input logic [31:0] p,
                       output logic rw, output logic [4:0] dst,
                       output logic [31:0] res, output logic ill);
    logic [31:0] a, b, se, ze;
    logic [4:0]  sh;
    a  = rv(ins[25:21]);
    b  = rv(ins[20:16]);
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0, ins[15:0]};
    sh = ins[10:6];
    rw = 1'b1; ill = 1'b0; res = 32'h0; dst = ins[20:16];
    case (ins[31:26])
      6'h00: begin
        dst = ins[15:11];
        case (ins[5:0])
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: res = (a < b) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = $signed(b) >>> sh;
          6'h04: res = b << a[4:0];
          6'h06: res = b >> a[4:0];
          6'h07: res = $signed(b) >>> a[4:0];
          default: ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: res = a + se;
      6'h0A: res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
      6'h0B: res = (a < se) ? 32'd1 : 32'd0;
      6'h0C: res = a & ze;
      6'h0D: res = a | ze;
      6'h0E: res = a ^ ze;
      6'h0F: res = {ins[15:0], 16'h0};
      6'h03: begin dst = 5'd31; res = p + 32'd8; end
      default: ill = 1'b1;
    endcase
    if (ill) begin rw = 1'b0; res = 32'h0; end
  endtask

  // One cycle: drive, check combinational outputs and pre-edge state, clock, update model
  task automatic run(input logic [31:0] ins, input logic v);
    logic rw, ill; logic [4:0] dst; logic [31:0] res; logic exp_we;
    model(ins, cur_pc, rw, dst, res, ill);
    exp_we = v && rw && (dst != 0);
    instr = ins; instr_valid = v; pc = cur_pc;
    dbg_addr = ($urandom_range(0, 1) == 1) ? dst : 5'($urandom);
    #2;
    chk("alu_result", alu_result, res);
    chk("wb_data", wb_data, res);
    chk("wb_we", {31'h0, wb_we}, {31'h0, exp_we});
    chk("illegal", {31'h0, illegal}, {31'h0, v && ill});
    if (!ill) chk("wb_addr", {27'h0, wb_addr}, {27'h0, dst});
    chk("dbg_old", dbg_data, rv(dbg_addr));
    @(posedge clk);
    if (exp_we) mregs[dst] = res;
    #1;
    cur_pc = cur_pc + 32'd4;
  endtask

  initial begin
    logic [5:0] rfun [16];
    logic [5:0] iops [8];
    logic [31:0] ins;
    rfun = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    iops = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    reset = 1'b0; instr_valid = 1'b0; instr = 32'h0; pc = 32'h0; dbg_addr = 5'd0;
    #12;
    chk("rst_wb_we", {31'h0, wb_we}, 32'h0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      chk("reset_reg", dbg_data, 32'h0);
    end
    chk("reset_wb_we", {31'h0, wb_we}, 32'h0);

    run(it_enc(6'h0D, 0, 1, 16'h1234), 1'b1);
    run(it_enc(6'h0F, 0, 2, 16'hABCD), 1'b1);
    run(it_enc(6'h08, 0, 3, 16'hFFFF), 1'b1);
    run(rt_enc(6'h20, 3, 1, 4, 0), 1'b1);
    run(rt_enc(6'h22, 0, 1, 5, 0), 1'b1);
    run(rt_enc(6'h2A, 3, 1, 6, 0), 1'b1);
    run(rt_enc(6'h2B, 3, 1, 7, 0), 1'b1);
    run(rt_enc(6'h03, 0, 2, 8, 4), 1'b1);
    run(rt_enc(6'h02, 0, 2, 9, 4), 1'b1);
    cur_pc = 32'h0000_3010;
    instr = 32'h0C00_0000; instr_valid = 1'b1; pc = cur_pc; #1;
    chk("jal_wb_addr", {27'h0, wb_addr}, 32'd31);
    run(32'h0C00_0000, 1'b1);
    run(it_enc(6'h0D, 0, 0, 16'h0005), 1'b1);
    run(32'hFC00_0000, 1'b1);
    run(rt_enc(6'h20, 3, 3, 10, 0), 1'b0);
    run(32'h0000_0000, 1'b1);
    instr_valid = 1'b0;
    begin
      logic [31:0] expv [12];
      logic [4:0]  adr  [12];
      adr  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd31, 5'd0, 5'd10};
      expv = '{32'h0000_1234, 32'hABCD_0000, 32'hFFFF_FFFF, 32'h0000_1233, 32'hFFFF_EDCC,
               32'h1, 32'h0, 32'hFABC_D000, 32'h0ABC_D000, 32'h0000_3018, 32'h0, 32'h0};
      for (int i = 0; i < 12; i++) begin
        dbg_addr = adr[i]; #1;
        chk($sformatf("plan_reg%0d", adr[i]), dbg_data, expv[i]);
      end
    end

    // read-during-write and async reset cancelling a write
    run(it_enc(6'h0D, 0, 1, 16'h0005), 1'b1);
    instr = it_enc(6'h08, 1, 1, 16'h0001); instr_valid = 1'b1; dbg_addr = 5'd1; #2;
    chk("rdw_alu", alu_result, 32'd6);
    chk("rdw_old", dbg_data, 32'd5);
    @(posedge clk); #1;
    chk("rdw_new", dbg_data, 32'd6);
    #1;
    chk("pre_rst_alu", alu_result, 32'd7);
    reset = 1'b0; #1;
    chk("async_clr", dbg_data, 32'd0);
    chk("rst_we", {31'h0, wb_we}, 32'h0);
    chk("rst_alu", alu_result, 32'd1);
    @(posedge clk); #1;
    chk("rst_nowrite", dbg_data, 32'd0);
    instr = 32'hFC00_0000; #1;
    chk("rst_illegal", {31'h0, illegal}, 32'h0);
    instr_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1: ins = rt_enc(rfun[$urandom_range(0, 15)], 5'($urandom), 5'($urandom),
                           5'($urandom), 5'($urandom));
        2, 3: ins = it_enc(iops[$urandom_range(0, 7)], 5'($urandom), 5'($urandom),
                           16'($urandom));
        4:    ins = {6'h03, 26'($urandom)};
        default: ins = $urandom;
      endcase
      run(ins, $urandom_range(0, 9) != 0);
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      chk("final_reg", dbg_data, rv(5'(i)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
